// File: rtl/pc_tx_framer_pkg.sv
// Shared definitions for the PC link TX framer: FSM states, header field
// positions and the default sync byte.
package pc_tx_framer_pkg;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_HEADER,
    ST_PAYLOAD,
    ST_TRAILER
  } framer_state_t;

  localparam int HDR_SYNC_LSB = 24;
  localparam int HDR_CMD_LSB  = 16;
  localparam int HDR_SEQ_LSB  = 8;
  localparam int HDR_LEN_LSB  = 0;

  localparam logic [7:0] DEFAULT_SYNC_BYTE = 8'hA5;

  function automatic logic [31:0] make_header(input logic [7:0] sync,
                                              input logic [7:0] cmd,
                                              input logic [7:0] seq,
                                              input logic [7:0] len);
    logic [31:0] h;
    h = '0;
    h[HDR_SYNC_LSB +: 8] = sync;
    h[HDR_CMD_LSB  +: 8] = cmd;
    h[HDR_SEQ_LSB  +: 8] = seq;
    h[HDR_LEN_LSB  +: 8] = len;
    return h;
  endfunction

endpackage

// File: rtl/frame_checksum.sv
// 32-bit modular running sum with clear/accumulate controls and a registered
// value; shared by the TX framer and the RX frame checker.
module frame_checksum (
  input  logic        i_clock,
  input  logic        i_reset,
  input  logic        clear,
  input  logic        accumulate,
  input  logic [31:0] data,
  output logic [31:0] value
);

  // NOTE: sequential state uses non-blocking (<=) so every register in the
  // design samples pre-edge values regardless of evaluation order.
  always_ff @(posedge i_clock) begin
    if (i_reset || clear) begin
      value <= '0;
    end else if (accumulate) begin
      value <= value + data;
    end
  end

endmodule

// File: rtl/pc_tx_framer.sv
// Frames header + payload + checksum trailer into PC_TX's word-write port.
// Define PC_TX_FRAMER_TIMEOUT_EN to abort stalled payloads with a corrupt trailer.
module pc_tx_framer
  import pc_tx_framer_pkg::*;
#(
  parameter int         MAX_PAYLOAD_WORDS = 16,
  parameter logic [7:0] SYNC_BYTE         = DEFAULT_SYNC_BYTE
`ifdef PC_TX_FRAMER_TIMEOUT_EN
  , parameter int       TIMEOUT_CYCLES    = 1024
`endif
) (
  input  logic        i_clock,
  input  logic        i_reset,
  input  logic        i_frame_start,
  input  logic [7:0]  i_frame_cmd,
  input  logic [7:0]  i_frame_len,
  output logic        o_frame_busy,
  input  logic [31:0] i_payload_data,
  input  logic        i_payload_valid,
  output logic        o_payload_ready,
  input  logic        i_dst_ready,
  output logic [31:0] o_fifo_write_word_data,
  output logic        o_fifo_write_word_cmd,
  output logic        o_frame_done,
  output logic        o_frame_error
);

  localparam logic [7:0] MAX_LEN = 8'(MAX_PAYLOAD_WORDS);

  framer_state_t state;
  logic [7:0]    cmd_q;
  logic [7:0]    len_q;
  logic [7:0]    remaining;
  logic [7:0]    seq;
  logic [31:0]   header_word;
  logic [31:0]   csum_value;
  logic [31:0]   csum_data;
  logic          len_ok;
  logic          accept;
  logic          xfer;
  logic          csum_add;
  logic          timed_out;
  logic          stall_expire;

  assign len_ok          = (i_frame_len != 8'd0) && (i_frame_len <= MAX_LEN);
  assign accept          = (state == ST_IDLE) && i_frame_start && len_ok;
  assign o_payload_ready = (state == ST_PAYLOAD) && i_dst_ready;
  assign xfer            = o_payload_ready && i_payload_valid;
  assign header_word     = make_header(SYNC_BYTE, cmd_q, seq, len_q);
  assign csum_add        = ((state == ST_HEADER) && i_dst_ready) || xfer;
  assign csum_data       = (state == ST_HEADER) ? header_word : i_payload_data;

  frame_checksum u_checksum (
    .i_clock    (i_clock),
    .i_reset    (i_reset),
    .clear      (accept),
    .accumulate (csum_add),
    .data       (csum_data),
    .value      (csum_value)
  );

`ifdef PC_TX_FRAMER_TIMEOUT_EN
  localparam int TW = $clog2(TIMEOUT_CYCLES + 1);
  logic [TW-1:0] stall_cnt;

  // Expires on the TIMEOUT_CYCLES-th consecutive PAYLOAD cycle without a transfer.
  assign stall_expire = (state == ST_PAYLOAD) && !xfer &&
                        (stall_cnt == TW'(TIMEOUT_CYCLES - 1));

  always_ff @(posedge i_clock) begin
    if (i_reset) begin
      stall_cnt <= '0;
      timed_out <= 1'b0;
    end else begin
      if (state != ST_PAYLOAD || xfer || stall_expire) begin
        stall_cnt <= '0;
      end else begin
        stall_cnt <= stall_cnt + 1'b1;
      end
      if (accept) begin
        timed_out <= 1'b0;
      end else if (stall_expire) begin
        timed_out <= 1'b1;
      end
    end
  end
`else
  assign stall_expire = 1'b0;
  assign timed_out    = 1'b0;
`endif

  always_ff @(posedge i_clock) begin
    if (i_reset) begin
      state                  <= ST_IDLE;
      cmd_q                  <= '0;
      len_q                  <= '0;
      remaining              <= '0;
      seq                    <= '0;
      o_frame_busy           <= 1'b0;
      o_fifo_write_word_data <= '0;
      o_fifo_write_word_cmd  <= 1'b0;
      o_frame_done           <= 1'b0;
      o_frame_error          <= 1'b0;
    end else begin
      o_fifo_write_word_cmd <= 1'b0;
      o_frame_done          <= 1'b0;
      o_frame_error         <= 1'b0;

      case (state)
        ST_IDLE: begin
          // Busy drops one cycle after the trailer strobe, unless a new frame starts.
          o_frame_busy <= accept;
          if (accept) begin
            cmd_q     <= i_frame_cmd;
            len_q     <= i_frame_len;
            remaining <= i_frame_len;
            state     <= ST_HEADER;
          end else if (i_frame_start) begin
            o_frame_error <= 1'b1;
          end
        end

        ST_HEADER: begin
          if (i_dst_ready) begin
            o_fifo_write_word_data <= header_word;
            o_fifo_write_word_cmd  <= 1'b1;
            state                  <= ST_PAYLOAD;
          end
        end

        ST_PAYLOAD: begin
          if (xfer) begin
            o_fifo_write_word_data <= i_payload_data;
            o_fifo_write_word_cmd  <= 1'b1;
            remaining              <= remaining - 8'd1;
            if (remaining == 8'd1) begin
              state <= ST_TRAILER;
            end
          end else if (stall_expire) begin
            state <= ST_TRAILER;
          end
        end

        ST_TRAILER: begin
          if (i_dst_ready) begin
            o_fifo_write_word_data <= timed_out ? ~csum_value : csum_value;
            o_fifo_write_word_cmd  <= 1'b1;
            o_frame_done           <= !timed_out;
            o_frame_error          <= timed_out;
            seq                    <= seq + 8'd1;
            state                  <= ST_IDLE;
          end
        end

        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_pc_tx_framer.sv
// Self-checking bench for pc_tx_framer: directed frames plus randomized
// payload/backpressure checked against a word-list frame model.
module tb_pc_tx_framer;

  logic        i_clock         = 1'b0;
  logic        i_reset         = 1'b1;
  logic        i_frame_start   = 1'b0;
  logic [7:0]  i_frame_cmd     = '0;
  logic [7:0]  i_frame_len     = '0;
  logic        o_frame_busy;
  logic [31:0] i_payload_data  = '0;
  logic        i_payload_valid = 1'b0;
  logic        o_payload_ready;
  logic        i_dst_ready     = 1'b1;
  logic [31:0] o_fifo_write_word_data;
  logic        o_fifo_write_word_cmd;
  logic        o_frame_done;
  logic        o_frame_error;

  pc_tx_framer #(
    .MAX_PAYLOAD_WORDS (16),
    .SYNC_BYTE         (8'hA5)
`ifdef PC_TX_FRAMER_TIMEOUT_EN
    , .TIMEOUT_CYCLES  (8)
`endif
  ) dut (
    .i_clock                (i_clock),
    .i_reset                (i_reset),
    .i_frame_start          (i_frame_start),
    .i_frame_cmd            (i_frame_cmd),
    .i_frame_len            (i_frame_len),
    .o_frame_busy           (o_frame_busy),
    .i_payload_data         (i_payload_data),
    .i_payload_valid        (i_payload_valid),
    .o_payload_ready        (o_payload_ready),
    .i_dst_ready            (i_dst_ready),
    .o_fifo_write_word_data (o_fifo_write_word_data),
    .o_fifo_write_word_cmd  (o_fifo_write_word_cmd),
    .o_frame_done           (o_frame_done),
    .o_frame_error          (o_frame_error)
  );

  always #10 i_clock = ~i_clock;

  int          total = 0;
  int          bad   = 0;
  int unsigned cyc   = 0;
  always @(posedge i_clock) cyc <= cyc + 1;

  // Payload source and downstream-ready driver.
  logic [31:0] pay_q[$];
  int          ready_mode  = 0;  // 0: always high, 1: toggle, 2: random
  int          valid_rand  = 0;
  int          xfers       = 0;
  bit          pop_pending = 1'b0;

  always @(posedge i_clock) begin
    #1;
    if (pop_pending && pay_q.size() > 0) void'(pay_q.pop_front());
    pop_pending = 1'b0;
    case (ready_mode)
      0:       i_dst_ready = 1'b1;
      1:       i_dst_ready = ~i_dst_ready;
      default: i_dst_ready = 1'($urandom_range(0, 1));
    endcase
    if (pay_q.size() > 0 && (valid_rand == 0 || $urandom_range(0, 3) != 0)) begin
      i_payload_valid = 1'b1;
      i_payload_data  = pay_q[0];
    end else begin
      i_payload_valid = 1'b0;
      i_payload_data  = $urandom;
    end
  end

  // Output monitor.
  logic [31:0] mon_q[$];
  int unsigned mon_cyc[$];
  bit          mon_done[$];
  bit          mon_err[$];
  bit          mon_busy[$];
  int          strobes     = 0;
  int          err_pulses  = 0;
  int          done_pulses = 0;
  int          rdy_viol    = 0;
  int          pay_viol    = 0;
  bit          last_rdy    = 1'b0;

  always @(negedge i_clock) begin
    if (i_payload_valid && o_payload_ready) begin
      pop_pending = 1'b1;
      xfers++;
    end
    if (o_fifo_write_word_cmd) begin
      mon_q.push_back(o_fifo_write_word_data);
      mon_cyc.push_back(cyc);
      mon_done.push_back(o_frame_done);
      mon_err.push_back(o_frame_error);
      mon_busy.push_back(o_frame_busy);
      strobes++;
      if (!last_rdy) rdy_viol++;
    end
    if (o_frame_done) done_pulses++;
    if (o_frame_error) err_pulses++;
    if (o_payload_ready && !i_dst_ready) pay_viol++;
    last_rdy = i_dst_ready;
  end

  logic [7:0] model_seq  = 8'd0;
  int         model_done = 0;
  int         model_err  = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    total++;
    assert (obs === expv) else begin
      bad++;
      $error("FAIL %s: observed=%h expected=%h", tag, obs, expv);
    end
  endtask

  task automatic step();
    @(posedge i_clock);
    #1;
  endtask

  task automatic clear_mon();
    mon_q.delete();
    mon_cyc.delete();
    mon_done.delete();
    mon_err.delete();
    mon_busy.delete();
  endtask

  // Builds the expected word list from the frame rules, runs one frame, compares.
  task automatic run_frame(input logic [7:0] cmd, input int len, input bit fixed,
                           input bit spurious, input bit timed, input string tag);
    logic [31:0] exp_q[$];
    logic [31:0] w;
    logic [31:0] sum;
    int unsigned start_cyc;
    int          n;
    clear_mon();
    w = {8'hA5, cmd, model_seq, 8'(len)};
    exp_q.push_back(w);
    sum = w;
    for (int i = 0; i < len; i++) begin
      w = fixed ? 32'(i + 1) : $urandom;
      pay_q.push_back(w);
      exp_q.push_back(w);
      sum += w;
    end
    exp_q.push_back(sum);

    i_frame_cmd   = cmd;
    i_frame_len   = 8'(len);
    i_frame_start = 1'b1;
    step();
    i_frame_start = 1'b0;
    start_cyc     = cyc;
    check({tag, " busy_after_start"}, 32'(o_frame_busy), 32'd1);

    for (int k = 0; k < 2000 && mon_q.size() < exp_q.size(); k++) begin
      step();
      if (spurious && k == 0) begin
        i_frame_cmd   = 8'hEE;
        i_frame_len   = 8'd1;
        i_frame_start = 1'b1;
      end else begin
        i_frame_start = 1'b0;
      end
    end
    i_frame_start = 1'b0;

    check({tag, " word_count"}, 32'(mon_q.size()), 32'(exp_q.size()));
    check({tag, " busy_after_trailer"}, 32'(o_frame_busy), 32'd0);
    n = (mon_q.size() < exp_q.size()) ? mon_q.size() : exp_q.size();
    for (int i = 0; i < n; i++) begin
      check($sformatf("%s word%0d", tag, i), mon_q[i], exp_q[i]);
      check($sformatf("%s done%0d", tag, i), 32'(mon_done[i]), 32'(i == exp_q.size() - 1));
      check($sformatf("%s err%0d", tag, i), 32'(mon_err[i]), 32'd0);
      check($sformatf("%s busy%0d", tag, i), 32'(mon_busy[i]), 32'd1);
      if (timed) check($sformatf("%s cycle%0d", tag, i), mon_cyc[i], start_cyc + 1 + i);
    end
    model_seq  = model_seq + 8'd1;
    model_done++;
  endtask

  task automatic bad_req(input logic [7:0] len, input string tag);
    int e0 = err_pulses;
    int s0 = strobes;
    i_frame_cmd   = 8'h34;
    i_frame_len   = len;
    i_frame_start = 1'b1;
    step();
    i_frame_start = 1'b0;
    check({tag, " err_pulse"}, 32'(o_frame_error), 32'd1);
    check({tag, " busy"}, 32'(o_frame_busy), 32'd0);
    repeat (4) step();
    check({tag, " err_count"}, 32'(err_pulses - e0), 32'd1);
    check({tag, " no_strobe"}, 32'(strobes - s0), 32'd0);
    model_err++;
  endtask

  initial begin
    logic [31:0] hdr;
    int          x0;

    // Reset state.
    repeat (3) step();
    check("rst data", o_fifo_write_word_data, 32'd0);
    check("rst strobe", 32'(o_fifo_write_word_cmd), 32'd0);
    check("rst busy", 32'(o_frame_busy), 32'd0);
    check("rst done", 32'(o_frame_done), 32'd0);
    check("rst err", 32'(o_frame_error), 32'd0);
    check("rst pready", 32'(o_payload_ready), 32'd0);
    i_reset = 1'b0;
    step();

    // Reference frame, minimum-latency timing, then the same frame with seq=1.
    run_frame(8'h12, 3, 1'b1, 1'b0, 1'b1, "f1");
    if (mon_q.size() == 5) begin
      check("f1 hdr_const", mon_q[0], 32'hA5120003);
      check("f1 sum_const", mon_q[4], 32'hA5120009);
    end
    run_frame(8'h12, 3, 1'b1, 1'b0, 1'b1, "f2");
    if (mon_q.size() > 0) check("f2 hdr_const", mon_q[0], 32'hA5120103);

    // Largest legal length at full rate.
    run_frame(8'h21, 16, 1'b0, 1'b0, 1'b1, "max");

    // Illegal lengths leave seq untouched.
    bad_req(8'd0, "len0");
    bad_req(8'd17, "len17");
    run_frame(8'h33, 1, 1'b0, 1'b0, 1'b1, "after_bad");

    // Ready toggling every cycle, with a start request while busy.
    ready_mode = 1;
    run_frame(8'h44, 4, 1'b0, 1'b1, 1'b0, "toggle");
    check("toggle rdy_viol", 32'(rdy_viol), 32'd0);
    check("toggle pay_viol", 32'(pay_viol), 32'd0);
    ready_mode = 0;
    step();

    // Reset after the second payload word of a len=5 frame.
    for (int i = 0; i < 5; i++) pay_q.push_back(32'h100 + 32'(i));
    x0 = xfers;
    i_frame_cmd   = 8'h56;
    i_frame_len   = 8'd5;
    i_frame_start = 1'b1;
    step();
    i_frame_start = 1'b0;
    for (int k = 0; k < 100 && xfers < x0 + 2; k++) step();
    check("rst_mid xfers", 32'(xfers - x0), 32'd2);
    i_reset = 1'b1;
    step();
    check("rst_mid data", o_fifo_write_word_data, 32'd0);
    check("rst_mid strobe", 32'(o_fifo_write_word_cmd), 32'd0);
    check("rst_mid busy", 32'(o_frame_busy), 32'd0);
    check("rst_mid done", 32'(o_frame_done), 32'd0);
    check("rst_mid pready", 32'(o_payload_ready), 32'd0);
    i_reset = 1'b0;
    pay_q.delete();
    model_seq = 8'd0;
    step();
    run_frame(8'h78, 2, 1'b0, 1'b0, 1'b1, "post_rst");
    if (mon_q.size() > 0) begin
      hdr = mon_q[0];
      check("post_rst seq", 32'(hdr[15:8]), 32'd0);
    end

    // Randomized frames walk seq through a full wrap.
    ready_mode = 2;
    valid_rand = 1;
    for (int f = 0; f < 255; f++) begin
      run_frame(8'($urandom), int'($urandom_range(1, 16)), 1'b0,
                1'($urandom_range(0, 1)), 1'b0, $sformatf("rnd%0d", f));
    end
    ready_mode = 0;
    valid_rand = 0;
    step();
    run_frame(8'h12, 3, 1'b1, 1'b0, 1'b1, "wrap");
    if (mon_q.size() > 0) begin
      hdr = mon_q[0];
      check("wrap seq", 32'(hdr[15:8]), 32'd0);
    end

`ifdef PC_TX_FRAMER_TIMEOUT_EN
    // Stalled payload: one of two words supplied, trailer is the inverted sum.
    clear_mon();
    pay_q.push_back(32'h10);
    i_frame_cmd   = 8'h9A;
    i_frame_len   = 8'd2;
    i_frame_start = 1'b1;
    step();
    i_frame_start = 1'b0;
    for (int k = 0; k < 300 && mon_q.size() < 3; k++) step();
    check("tmo count", 32'(mon_q.size()), 32'd3);
    if (mon_q.size() >= 3) begin
      hdr = {8'hA5, 8'h9A, model_seq, 8'h02};
      check("tmo hdr", mon_q[0], hdr);
      check("tmo pay", mon_q[1], 32'h10);
      check("tmo trailer", mon_q[2], ~(hdr + 32'h10));
      check("tmo err", 32'(mon_err[2]), 32'd1);
      check("tmo done", 32'(mon_done[2]), 32'd0);
    end
    model_seq = model_seq + 8'd1;
    model_err++;
    repeat (3) step();
`endif

    check("all rdy_viol", 32'(rdy_viol), 32'd0);
    check("all pay_viol", 32'(pay_viol), 32'd0);
    check("all done_pulses", 32'(done_pulses), 32'(model_done));
    check("all err_pulses", 32'(err_pulses), 32'(model_err));

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/pc_tx_framer.md
# pc_tx_framer

Packetises response data for the PC link. Accepts a frame request (command byte plus payload length), pulls payload words over a valid/ready port, and emits a framed word stream into PC_TX's word-write interface:

- header word
- N payload words
- checksum trailer word

Sits directly upstream of PC_TX, replacing ad-hoc word dumping by the DataRouter. It throttles on a downstream-ready input so PC_TX never silently drops words.

## Interface
- MAX_PAYLOAD_WORDS, 16, largest legal frame length (1..255)
- SYNC_BYTE, 8'hA5, header bits [31:24]
- TIMEOUT_CYCLES, 1024, payload stall limit (used only with the timeout feature)

- i_clock  in  1  system clock (50 MHz)
- i_reset  in  1  synchronous, active-high reset
- i_frame_start  in  1  single-cycle frame request; honoured only in IDLE
- i_frame_cmd  in  8  command byte, sampled with i_frame_start
- i_frame_len  in  8  payload word count, sampled with i_frame_start
- o_frame_busy  out  1  high from the cycle after an accepted start until the trailer strobe
- i_payload_data  in  32  payload word
- i_payload_valid  in  1  payload word present
- o_payload_ready  out  1  framer accepts payload this cycle
- i_dst_ready  in  1  PC_TX can take a word (top level: FIFO not full)
- o_fifo_write_word_data  out  32  word to PC_TX
- o_fifo_write_word_cmd  out  1  one-cycle write strobe per word
- o_frame_done  out  1  one-cycle pulse, coincident with the trailer strobe
- o_frame_error  out  1  one-cycle pulse on a rejected request or an aborted frame

## Operation
- FSM states are IDLE, HEADER, PAYLOAD, TRAILER.
- **IDLE**
  - On i_frame_start with 1 ≤ i_frame_len ≤ MAX_PAYLOAD_WORDS: latch cmd and len, clear checksum, go to HEADER.
  - On an illegal length: pulse o_frame_error the next cycle, stay in IDLE, leave seq unchanged.
- **HEADER**
  - When i_dst_ready=1: load header {SYNC_BYTE, cmd, seq[7:0], len} onto the output, add it to the checksum, go to PAYLOAD.
- **PAYLOAD**
  - o_payload_ready = i_dst_ready.
  - On valid&ready: load i_payload_data onto the output, add it to the checksum, decrement the remaining count.
  - After the last word, go to TRAILER.
- **TRAILER**
  - When i_dst_ready=1: load the checksum, pulse o_frame_done, increment seq (wraps 255→0), go to IDLE.
- **Checksum:** 32-bit sum of header and payload words, modulo 2^32, carries discarded.
- **Throughput:** at most one word per cycle; back-to-back payload at full rate when i_dst_ready is held high.
- i_frame_start while busy is ignored; no queuing, no error.
- i_dst_ready falling mid-frame pauses the frame in its current state; no word is lost or duplicated.
- i_reset mid-frame: abandon the frame (no trailer), return to IDLE, seq=0.

## Timing
- **Reset values:** all outputs 0, state IDLE, seq 0, checksum 0.
- **Registered outputs:** data and strobe update on the edge where the state condition and i_dst_ready are sampled high. The strobe is visible the following cycle, for exactly one cycle per word.
- **Start latency:** start sampled at cycle N → HEADER at N+1 → header strobe earliest at N+2.
- **Minimum frame:** for len L with i_dst_ready constant 1 and payload always valid, the trailer strobe occurs at N+3+L. o_frame_busy falls after that cycle.
- o_payload_ready is combinational from state and i_dst_ready only, never from i_payload_valid.

## Configuration
- **PC_TX_FRAMER_TIMEOUT_EN defined:**
  - In PAYLOAD, a counter increments each cycle without a valid&ready transfer and resets on a transfer.
  - On reaching TIMEOUT_CYCLES, go to TRAILER and emit ~checksum (bitwise-inverted) as the corrupt-frame marker.
  - Pulse o_frame_error with the trailer strobe instead of o_frame_done. seq still increments.
- **Undefined:** PAYLOAD waits indefinitely; no counter logic is synthesised.

## Structure
- Shared package pc_tx_framer_pkg holds:
  - the state enumeration
  - header field positions (SYNC [31:24], CMD [23:16], SEQ [15:8], LEN [7:0])
  - the default SYNC_BYTE
- One sub-module, frame_checksum: clear/accumulate/value, 32-bit modular adder with a registered sum. It is reused later by the PC_RX frame checker.

## Test plan
- Start cmd=8'h12, len=3, payload 32'h1, 32'h2, 32'h3, i_dst_ready=1:
  - Words A5120003, 1, 2, 3, A5120009 on consecutive strobe cycles.
  - o_frame_done coincides with the last word.
- Second identical frame: header A5120103 (seq=1). 256 frames: seq wraps to 00.
- len=0 and len=17: o_frame_error pulse, no strobe, and the next legal frame still uses the previous seq.
- i_dst_ready toggled 1/0 every cycle during a len=4 frame:
  - Exactly 6 strobes, in order, each only after a ready-high sample.
  - Payload never accepted while ready=0.
- i_reset asserted after the second payload word of len=5: outputs 0 the next cycle; a following frame's header shows seq=00.
- PC_TX_FRAMER_TIMEOUT_EN, TIMEOUT_CYCLES=8, len=2, only one payload word of 32'h10 supplied: header A5xx..02, then 32'h10, then trailer ~(header+32'h10) plus o_frame_error eight cycles after the last transfer.
